fibonacci_cpu: RTL and testbench

- Self-contained single-cycle RV32I-subset CPU with a hard-wired program ROM that computes the first 10 Fibonacci numbers (1,1,2,3,5,8,13,21,34,55).
- Stores the results to data RAM words 0..9, reloads them into x15..x24, then parks in a self-loop.
- Sub-instances, named exactly: u_pc (reg pc), u_regfile (array regs[0:31]), u_dmem (array ram[]), u_control (output mem_write).
- Top-level nets, named exactly: inst, alu_result, branch_taken.

---
 rtl/fibonacci_cpu.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_fibonacci_cpu.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fibonacci_cpu.sv
// Single-cycle RV32I-subset CPU with a hard-wired ROM that writes the first ten Fibonacci numbers.
// Optional per-instruction trace: define CPU_FIB_TRACE_EN.

package fib_pkg;
    localparam logic [2:0] AluAdd = 3'd0;
    localparam logic [2:0] AluSub = 3'd1;
    localparam logic [2:0] AluAnd = 3'd2;
    localparam logic [2:0] AluOr  = 3'd3;
    localparam logic [2:0] AluXor = 3'd4;
    localparam logic [2:0] AluSlt = 3'd5;

    localparam logic [1:0] ImmI = 2'd0;
    localparam logic [1:0] ImmS = 2'd1;
    localparam logic [1:0] ImmB = 2'd2;
    localparam logic [1:0] ImmJ = 2'd3;
endpackage

module fib_pc (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_next,
    output logic [31:0] pc
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end
endmodule

module fib_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  raddr1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata1,
    output logic [31:0] rdata2,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 5'd0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == 5'd0) ? 32'd0 : regs[raddr1];
    assign rdata2 = (raddr2 == 5'd0) ? 32'd0 : regs[raddr2];
endmodule

module fib_dmem #(
    parameter int unsigned DMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    output logic [31:0] rdata
);
    localparam int unsigned AW = $clog2(DMEM_DEPTH);

    logic [31:0]   ram [0:DMEM_DEPTH-1];
    logic [AW-1:0] idx;
    logic          unused_addr;

    assign idx         = addr[AW+1:2];
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DMEM_DEPTH); i++) begin
                ram[i] <= '0;
            end
        end else if (we) begin
            ram[idx] <= wdata;
        end
    end

    assign rdata = ram[idx];
endmodule

module fib_control (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_to_reg,
    output logic       alu_src_imm,
    output logic       is_branch,
    output logic       is_jal,
    output logic [2:0] alu_op,
    output logic [1:0] imm_sel
);
    import fib_pkg::*;

    // Anything not decoded below keeps these defaults, which retire as a NOP.
    always_comb begin
        reg_write   = 1'b0;
        mem_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_imm = 1'b0;
        is_branch   = 1'b0;
        is_jal      = 1'b0;
        alu_op      = AluAdd;
        imm_sel     = ImmI;
        case (opcode)
            7'b0110011: begin
                reg_write = 1'b1;
                case ({funct7, funct3})
                    {7'b0000000, 3'b000}: alu_op = AluAdd;
                    {7'b0100000, 3'b000}: alu_op = AluSub;
                    {7'b0000000, 3'b111}: alu_op = AluAnd;
                    {7'b0000000, 3'b110}: alu_op = AluOr;
                    {7'b0000000, 3'b100}: alu_op = AluXor;
                    {7'b0000000, 3'b010}: alu_op = AluSlt;
                    default:              reg_write = 1'b0;
                endcase
            end
            7'b0010011: begin
                if (funct3 == 3'b000) begin
                    reg_write   = 1'b1;
                    alu_src_imm = 1'b1;
                end
            end
            7'b0000011: begin
                if (funct3 == 3'b010) begin
                    reg_write   = 1'b1;
                    mem_to_reg  = 1'b1;
                    alu_src_imm = 1'b1;
                end
            end
            7'b0100011: begin
                if (funct3 == 3'b010) begin
                    mem_write   = 1'b1;
                    alu_src_imm = 1'b1;
                    imm_sel     = ImmS;
                end
            end
            7'b1100011: begin
                if (funct3 == 3'b000 || funct3 == 3'b001 ||
                    funct3 == 3'b100 || funct3 == 3'b101) begin
                    is_branch = 1'b1;
                    alu_op    = AluSub;
                    imm_sel   = ImmB;
                end
            end
            7'b1101111: begin
                reg_write = 1'b1;
                is_jal    = 1'b1;
                imm_sel   = ImmJ;
            end
            default: ;
        endcase
    end
endmodule

module fibonacci_cpu #(
    parameter int unsigned ROM_DEPTH  = 32,
    parameter int unsigned DMEM_DEPTH = 64
) (
    input logic clk,
    input logic rst
);
    import fib_pkg::*;

    logic [31:0] pc, pc_next, inst, imm, alu_a, alu_b, alu_result;
    logic [31:0] rs1_data, rs2_data, dmem_rdata, wb_data;
    logic [29:0] word_idx;
    logic        reg_write, mem_write, mem_to_reg, alu_src_imm, is_branch, is_jal;
    logic        branch_cond, branch_taken;
    logic [2:0]  alu_op;
    logic [1:0]  imm_sel;
    logic        unused_pc;

    assign word_idx  = pc[31:2];
    assign unused_pc = ^pc[1:0];

    // Fetch beyond the populated ROM depth yields NOP.
    always_comb begin
        inst = 32'h0000_0013;
        if (word_idx < 30'(ROM_DEPTH)) begin
            case (word_idx)
                30'd0:   inst = 32'h0010_0793; // addi x15,x0,1
                30'd1:   inst = 32'h0010_0813; // addi x16,x0,1
                30'd2:   inst = 32'h0020_0513; // addi x10,x0,2
                30'd3:   inst = 32'h00a0_0593; // addi x11,x0,10
                30'd4:   inst = 32'h0080_0693; // addi x13,x0,8
                30'd5:   inst = 32'h00f0_2023; // sw x15,0(x0)
                30'd6:   inst = 32'h0100_2223; // sw x16,4(x0)
                30'd7:   inst = 32'h02b5_5063; // bge x10,x11,+32
                30'd8:   inst = 32'h0107_88b3; // add x17,x15,x16
                30'd9:   inst = 32'h0116_a023; // sw x17,0(x13)
                30'd10:  inst = 32'h0008_0793; // addi x15,x16,0
                30'd11:  inst = 32'h0008_8813; // addi x16,x17,0
                30'd12:  inst = 32'h0015_0513; // addi x10,x10,1
                30'd13:  inst = 32'h0046_8693; // addi x13,x13,4
                30'd14:  inst = 32'hfe5f_f06f; // jal x0,-28
                30'd15:  inst = 32'h0000_0013; // nop
                30'd16:  inst = 32'h0000_2783; // lw x15,0(x0)
                30'd17:  inst = 32'h0040_2803;
                30'd18:  inst = 32'h0080_2883;
                30'd19:  inst = 32'h00c0_2903;
                30'd20:  inst = 32'h0100_2983;
                30'd21:  inst = 32'h0140_2a03;
                30'd22:  inst = 32'h0180_2a83;
                30'd23:  inst = 32'h01c0_2b03;
                30'd24:  inst = 32'h0200_2b83;
                30'd25:  inst = 32'h0240_2c03; // lw x24,36(x0)
                30'd26:  inst = 32'h0000_006f; // jal x0,0
                default: inst = 32'h0000_0013;
            endcase
        end
    end

    fib_control u_control (
        .opcode      (inst[6:0]),
        .funct3      (inst[14:12]),
        .funct7      (inst[31:25]),
        .reg_write   (reg_write),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .alu_src_imm (alu_src_imm),
        .is_branch   (is_branch),
        .is_jal      (is_jal),
        .alu_op      (alu_op),
        .imm_sel     (imm_sel)
    );

    always_comb begin
        imm = {{20{inst[31]}}, inst[31:20]};
        case (imm_sel)
            ImmS:    imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            ImmB:    imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            ImmJ:    imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm = {{20{inst[31]}}, inst[31:20]};
        endcase
    end

    fib_regfile u_regfile (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (inst[19:15]),
        .raddr2 (inst[24:20]),
        .rdata1 (rs1_data),
        .rdata2 (rs2_data),
        .we     (reg_write),
        .waddr  (inst[11:7]),
        .wdata  (wb_data)
    );

    assign alu_a = rs1_data;
    assign alu_b = alu_src_imm ? imm : rs2_data;

    always_comb begin
        alu_result = alu_a + alu_b;
        case (alu_op)
            AluSub:  alu_result = alu_a - alu_b;
            AluAnd:  alu_result = alu_a & alu_b;
            AluOr:   alu_result = alu_a | alu_b;
            AluXor:  alu_result = alu_a ^ alu_b;
            AluSlt:  alu_result = {31'd0, $signed(alu_a) < $signed(alu_b)};
            default: alu_result = alu_a + alu_b;
        endcase
    end

    // Compare operands directly so signed overflow of rs1-rs2 cannot flip blt/bge.
    always_comb begin
        branch_cond = 1'b0;
        case (inst[14:12])
            3'b000:  branch_cond = (rs1_data == rs2_data);
            3'b001:  branch_cond = (rs1_data != rs2_data);
            3'b100:  branch_cond = ($signed(rs1_data) < $signed(rs2_data));
            3'b101:  branch_cond = ($signed(rs1_data) >= $signed(rs2_data));
            default: branch_cond = 1'b0;
        endcase
    end

    assign branch_taken = is_branch && branch_cond;
    assign pc_next      = (branch_taken || is_jal) ? (pc + imm) : (pc + 32'd4);

    fib_dmem #(
        .DMEM_DEPTH (DMEM_DEPTH)
    ) u_dmem (
        .clk   (clk),
        .rst   (rst),
        .addr  (alu_result),
        .wdata (rs2_data),
        .we    (mem_write),
        .rdata (dmem_rdata)
    );

    assign wb_data = mem_to_reg ? dmem_rdata : (is_jal ? (pc + 32'd4) : alu_result);

    fib_pc u_pc (
        .clk     (clk),
        .rst     (rst),
        .pc_next (pc_next),
        .pc      (pc)
    );

`ifdef CPU_FIB_TRACE_EN
    always @(posedge clk) begin
        if (!rst) begin
            if (reg_write && (inst[11:7] != 5'd0)) begin
                $display("%0t pc=%08h inst=%08h x%0d=%08h", $time, pc, inst, inst[11:7], wb_data);
            end else if (mem_write) begin
                $display("%0t pc=%08h inst=%08h mem[%08h]=%08h", $time, pc, inst, alu_result,
                         rs2_data);
            end else begin
                $display("%0t pc=%08h inst=%08h", $time, pc, inst);
            end
        end
    end
`endif
endmodule

// File: tb/tb_fibonacci_cpu.sv
// Directed bench for fibonacci_cpu: reset, loop branch behaviour, store stream, final state,
// and asynchronous reset in the middle of the loop.
`timescale 1ns/100ps

module tb_fibonacci_cpu;
    logic clk = 1'b0;
    logic rst = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int st_count = 0;
    logic [31:0] st_addr [0:15];
    logic [31:0] st_data [0:15];
    logic [31:0] fib [0:9];

    fibonacci_cpu dut (
        .clk (clk),
        .rst (rst)
    );

    always #5 clk = ~clk;

    // Stores are sampled on the negedge before the posedge that commits them.
    always @(negedge clk) begin
        if (!rst) begin
            cyc = cyc + 1;
            if (dut.u_control.mem_write) begin
                if (st_count < 16) begin
                    st_addr[st_count] = dut.alu_result;
                    st_data[st_count] = dut.rs2_data;
                end
                st_count = st_count + 1;
            end
        end
    end

    task automatic test_reset;
        #1 rst = 1'b1;
        #10;
        checks++;
        if (dut.u_pc.pc !== 32'd0) begin
            failures++;
            $display("FAIL reset_pc got=%0h want=0", dut.u_pc.pc);
        end
        checks++;
        if (dut.u_regfile.regs[15] !== 32'd0) begin
            failures++;
            $display("FAIL reset_x15 got=%0h want=0", dut.u_regfile.regs[15]);
        end
        checks++;
        if (dut.u_dmem.ram[0] !== 32'd0) begin
            failures++;
            $display("FAIL reset_ram0 got=%0h want=0", dut.u_dmem.ram[0]);
        end
        @(negedge clk);
        #1;
        rst      = 1'b0;
        st_count = 0;
        cyc      = 0;
    endtask

    task automatic test_first_pass;
        int n = 0;
        @(negedge clk);
        while (dut.u_pc.pc !== 32'd28 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dut.u_pc.pc !== 32'd28) begin
            failures++;
            $display("FAIL first_pass_reach_pc28 got=%0d want=28", dut.u_pc.pc);
        end
        checks++;
        if (dut.u_regfile.regs[10] !== 32'd2) begin
            failures++;
            $display("FAIL first_pass_x10 got=%0d want=2", dut.u_regfile.regs[10]);
        end
        checks++;
        if (dut.u_regfile.regs[11] !== 32'd10) begin
            failures++;
            $display("FAIL first_pass_x11 got=%0d want=10", dut.u_regfile.regs[11]);
        end
        checks++;
        if (dut.branch_taken !== 1'b0) begin
            failures++;
            $display("FAIL first_pass_branch got=%0b want=0", dut.branch_taken);
        end
    endtask

    task automatic test_loop_exit;
        int n = 0;
        while (!(dut.u_pc.pc === 32'd28 && dut.u_regfile.regs[10] === 32'd10) && n < 150) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dut.branch_taken !== 1'b1) begin
            failures++;
            $display("FAIL exit_branch_taken got=%0b want=1", dut.branch_taken);
        end
        checks++;
        if (dut.alu_result !== 32'd0) begin
            failures++;
            $display("FAIL exit_alu_result got=%0h want=0", dut.alu_result);
        end
        @(negedge clk);
        checks++;
        if (dut.u_pc.pc !== 32'd60) begin
            failures++;
            $display("FAIL exit_next_pc got=%0d want=60", dut.u_pc.pc);
        end
    endtask

    task automatic test_completion(input int run);
        int n = 0;
        while (dut.u_pc.pc !== 32'd104 && n < 150) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dut.u_pc.pc !== 32'd104 || cyc >= 100) begin
            failures++;
            $display("FAIL run%0d_halt_reached pc=%0d cycles=%0d want pc=104 within 100", run,
                     dut.u_pc.pc, cyc);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (dut.u_pc.pc !== 32'd104) begin
                failures++;
                $display("FAIL run%0d_halt_hold%0d got=%0d want=104", run, i, dut.u_pc.pc);
            end
        end
        checks++;
        if (dut.inst !== 32'h0000_006f) begin
            failures++;
            $display("FAIL run%0d_halt_inst got=%08h want=0000006f", run, dut.inst);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (dut.u_dmem.ram[i] !== fib[i]) begin
                failures++;
                $display("FAIL run%0d_ram%0d got=%0d want=%0d", run, i, dut.u_dmem.ram[i], fib[i]);
            end
            checks++;
            if (dut.u_regfile.regs[15+i] !== fib[i]) begin
                failures++;
                $display("FAIL run%0d_x%0d got=%0d want=%0d", run, 15 + i,
                         dut.u_regfile.regs[15+i], fib[i]);
            end
        end
        checks++;
        if (dut.u_regfile.regs[10] !== 32'd10 || dut.u_regfile.regs[11] !== 32'd10 ||
            dut.u_regfile.regs[13] !== 32'd40) begin
            failures++;
            $display("FAIL run%0d_counters got x10=%0d x11=%0d x13=%0d want 10 10 40", run,
                     dut.u_regfile.regs[10], dut.u_regfile.regs[11], dut.u_regfile.regs[13]);
        end
        checks++;
        if (dut.u_regfile.regs[0] !== 32'd0) begin
            failures++;
            $display("FAIL run%0d_x0 got=%0h want=0", run, dut.u_regfile.regs[0]);
        end
        checks++;
        if (st_count != 10) begin
            failures++;
            $display("FAIL run%0d_store_count got=%0d want=10", run, st_count);
        end
        for (int i = 0; i < 10 && i < st_count; i++) begin
            checks++;
            if (st_addr[i] !== 32'(4 * i) || st_data[i] !== fib[i]) begin
                failures++;
                $display("FAIL run%0d_store%0d got addr=%0d data=%0d want addr=%0d data=%0d", run,
                         i, st_addr[i], st_data[i], 4 * i, fib[i]);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int n = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        rst      = 1'b0;
        st_count = 0;
        cyc      = 0;
        @(negedge clk);
        while (dut.u_pc.pc !== 32'd40 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (dut.u_pc.pc !== 32'd40 || dut.u_dmem.ram[0] !== 32'd1) begin
            failures++;
            $display("FAIL midrun_reach got pc=%0d ram0=%0d want pc=40 ram0=1", dut.u_pc.pc,
                     dut.u_dmem.ram[0]);
        end
        #2;
        rst = 1'b1;
        #0.5;
        checks++;
        if (dut.u_pc.pc !== 32'd0) begin
            failures++;
            $display("FAIL midrun_pc got=%0d want=0", dut.u_pc.pc);
        end
        checks++;
        if (dut.u_regfile.regs[15] !== 32'd0 || dut.u_regfile.regs[17] !== 32'd0) begin
            failures++;
            $display("FAIL midrun_regs got x15=%0d x17=%0d want 0 0", dut.u_regfile.regs[15],
                     dut.u_regfile.regs[17]);
        end
        checks++;
        if (dut.u_dmem.ram[0] !== 32'd0 || dut.u_dmem.ram[2] !== 32'd0) begin
            failures++;
            $display("FAIL midrun_ram got ram0=%0d ram2=%0d want 0 0", dut.u_dmem.ram[0],
                     dut.u_dmem.ram[2]);
        end
        #0.5;
        rst      = 1'b0;
        st_count = 0;
        cyc      = 0;
    endtask

    initial begin
        fib[0] = 32'd1;  fib[1] = 32'd1;  fib[2] = 32'd2;  fib[3] = 32'd3;  fib[4] = 32'd5;
        fib[5] = 32'd8;  fib[6] = 32'd13; fib[7] = 32'd21; fib[8] = 32'd34; fib[9] = 32'd55;
        test_reset();
        test_first_pass();
        test_loop_exit();
        test_completion(1);
        test_reset_mid_run();
        test_completion(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
